// File: rtl/rx_data_demux_pkg.sv
// Shared serial-frame definitions: frame marker, channel count, FSM
// encoding and the 8-bit checksum used by both rx and tx frame paths.
package rx_data_demux_pkg;

    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
    localparam int         NUM_CH        = 10;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ADDR = 3'd1,
        ST_DH   = 3'd2,
        ST_DL   = 3'd3,
        ST_CHK  = 3'd4
    } state_e;

    // Wrap-around sum of the frame body; the sync byte is never included.
    function automatic logic [7:0] sum8(input logic [7:0] a,
                                        input logic [7:0] b,
                                        input logic [7:0] c);
        return a + b + c;
    endfunction

endpackage

// File: rtl/rx_data_demux_strb_edge.sv
// Rising-edge detector for a byte-ready level. History resets to 1 so a
// strobe already high when reset releases is not seen as a new byte.
module strb_edge (
    input  logic clk,
    input  logic reset,
    input  logic strb,
    output logic rise
);

    logic pre_strb_q;
    logic pre_strb_d;

    always_comb pre_strb_d = strb;

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (reset) pre_strb_q <= 1'b1;
        else       pre_strb_q <= pre_strb_d;
    end

    assign rise = strb & ~pre_strb_q;

endmodule

// File: rtl/rx_data_demux.sv
// Assembles SYNC/ADDR/DATA_H/DATA_L/CHK frames from the UART byte stream
// and writes verified 16-bit payloads into ten holding registers.
module rx_data_demux
    import rx_data_demux_pkg::*;
#(
    parameter logic [7:0]  SYNC_BYTE = SYNC_BYTE_DEF,
    parameter int unsigned TIMEOUT   = 1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_strb,
    output logic [15:0] data_0,
    output logic [15:0] data_1,
    output logic [15:0] data_2,
    output logic [15:0] data_3,
    output logic [15:0] data_4,
    output logic [15:0] data_5,
    output logic [15:0] data_6,
    output logic [15:0] data_7,
    output logic [15:0] data_8,
    output logic [15:0] data_9,
    output logic        upd_strb,
    output logic [3:0]  upd_index,
    output logic        crc_err,
    output logic        addr_err,
    output logic        tout_err
);

    localparam logic [31:0] TOUT_LAST = 32'(TIMEOUT - 1);

    logic acc;

    state_e      state_q, state_d;
    logic [31:0] tcnt_q, tcnt_d;
    logic [7:0]  addr_q, addr_d;
    logic [7:0]  hi_q, hi_d;
    logic [7:0]  lo_q, lo_d;
    logic [15:0] data_q [NUM_CH];
    logic [15:0] data_d [NUM_CH];
    logic [3:0]  upd_index_q, upd_index_d;
    logic        upd_strb_q, upd_strb_d;
    logic        crc_err_q, crc_err_d;
    logic        addr_err_q, addr_err_d;
    logic        tout_err_q, tout_err_d;

    strb_edge u_strb_edge (
        .clk   (clk),
        .reset (reset),
        .strb  (rx_strb),
        .rise  (acc)
    );

    always_comb begin
        // NOTE: every next-state value gets a default first so no latch is inferred.
        state_d     = state_q;
        tcnt_d      = tcnt_q;
        addr_d      = addr_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        data_d      = data_q;
        upd_index_d = upd_index_q;
        upd_strb_d  = 1'b0;
        crc_err_d   = 1'b0;
        addr_err_d  = 1'b0;
        tout_err_d  = 1'b0;

        if (acc) begin
            tcnt_d = '0;
            case (state_q)
                ST_IDLE: if (rx_data == SYNC_BYTE) state_d = ST_ADDR;
                ST_ADDR: begin addr_d = rx_data; state_d = ST_DH; end
                ST_DH:   begin hi_d   = rx_data; state_d = ST_DL; end
                ST_DL:   begin lo_d   = rx_data; state_d = ST_CHK; end
                ST_CHK: begin
                    state_d = ST_IDLE;
                    if (rx_data != sum8(addr_q, hi_q, lo_q)) begin
                        crc_err_d = 1'b1;
                    end else if (addr_q < 8'(NUM_CH)) begin
                        for (int i = 0; i < NUM_CH; i++) begin
                            if (addr_q == 8'(i)) data_d[i] = {hi_q, lo_q};
                        end
                        upd_index_d = addr_q[3:0];
                        upd_strb_d  = 1'b1;
                    end else begin
                        addr_err_d = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end else if (state_q == ST_IDLE) begin
            tcnt_d = '0;
        end else if (TIMEOUT != 0 && tcnt_q == TOUT_LAST) begin
            // Partial frame is abandoned; a byte arriving this cycle would have won.
            state_d    = ST_IDLE;
            tcnt_d     = '0;
            tout_err_d = 1'b1;
        end else begin
            tcnt_d = tcnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            tcnt_q      <= '0;
            addr_q      <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            // NOTE: the holding registers are reset too; a mid-frame reset clears every output.
            for (int i = 0; i < NUM_CH; i++) data_q[i] <= '0;
            upd_index_q <= '0;
            upd_strb_q  <= 1'b0;
            crc_err_q   <= 1'b0;
            addr_err_q  <= 1'b0;
            tout_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            tcnt_q      <= tcnt_d;
            addr_q      <= addr_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            data_q      <= data_d;
            upd_index_q <= upd_index_d;
            upd_strb_q  <= upd_strb_d;
            crc_err_q   <= crc_err_d;
            addr_err_q  <= addr_err_d;
            tout_err_q  <= tout_err_d;
        end
    end

    assign data_0    = data_q[0];
    assign data_1    = data_q[1];
    assign data_2    = data_q[2];
    assign data_3    = data_q[3];
    assign data_4    = data_q[4];
    assign data_5    = data_q[5];
    assign data_6    = data_q[6];
    assign data_7    = data_q[7];
    assign data_8    = data_q[8];
    assign data_9    = data_q[9];
    assign upd_strb  = upd_strb_q;
    assign upd_index = upd_index_q;
    assign crc_err   = crc_err_q;
    assign addr_err  = addr_err_q;
    assign tout_err  = tout_err_q;

endmodule

// File: tb/tb_rx_data_demux.sv
// Self-checking bench for rx_data_demux: directed frames from the test plan
// plus randomized traffic compared every cycle against a byte-queue model.
module tb_rx_data_demux;

    localparam int TOUT = 1000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_strb = 1'b0;
    wire  [15:0] dut_data [10];
    wire         upd_strb, crc_err, addr_err, tout_err;
    wire  [3:0]  upd_index;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    rx_data_demux #(.SYNC_BYTE(8'hA5), .TIMEOUT(TOUT)) dut (
        .clk       (clk),
        .reset     (reset),
        .rx_data   (rx_data),
        .rx_strb   (rx_strb),
        .data_0    (dut_data[0]),
        .data_1    (dut_data[1]),
        .data_2    (dut_data[2]),
        .data_3    (dut_data[3]),
        .data_4    (dut_data[4]),
        .data_5    (dut_data[5]),
        .data_6    (dut_data[6]),
        .data_7    (dut_data[7]),
        .data_8    (dut_data[8]),
        .data_9    (dut_data[9]),
        .upd_strb  (upd_strb),
        .upd_index (upd_index),
        .crc_err   (crc_err),
        .addr_err  (addr_err),
        .tout_err  (tout_err)
    );

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: a frame is a sync byte followed by a queue of four body bytes.
    logic [15:0] m_data [10];
    logic [3:0]  m_idx;
    logic        m_upd, m_crc, m_adr, m_tout;
    logic        m_prev;
    bit          in_frame;
    int          gap;
    logic [7:0]  body [$];
    int          upd_seen, crc_seen, adr_seen, tout_seen;

    task automatic model_step();
        bit acc;
        int sum;
        m_upd = 0; m_crc = 0; m_adr = 0; m_tout = 0;
        if (reset) begin
            for (int i = 0; i < 10; i++) m_data[i] = 16'h0;
            m_idx = 0; in_frame = 0; gap = 0; body.delete(); m_prev = 1;
        end else begin
            acc = rx_strb && !m_prev;
            if (acc) begin
                gap = 0;
                if (!in_frame) begin
                    if (rx_data == 8'hA5) begin in_frame = 1; body.delete(); end
                end else begin
                    body.push_back(rx_data);
                    if (body.size() == 4) begin
                        sum = (int'(body[0]) + int'(body[1]) + int'(body[2])) % 256;
                        if (sum != int'(body[3])) m_crc = 1;
                        else if (body[0] < 10) begin
                            m_data[body[0]] = {body[1], body[2]};
                            m_idx = body[0][3:0];
                            m_upd = 1;
                        end else m_adr = 1;
                        in_frame = 0;
                    end
                end
            end else if (in_frame) begin
                gap++;
                if (gap == TOUT) begin m_tout = 1; in_frame = 0; gap = 0; end
            end
            m_prev = rx_strb;
        end
    endtask

    always @(posedge clk) begin
        model_step();
        #1;
        for (int i = 0; i < 10; i++) check($sformatf("data_%0d", i), dut_data[i], m_data[i]);
        check("upd_strb", 16'(upd_strb), 16'(m_upd));
        check("upd_index", 16'(upd_index), 16'(m_idx));
        check("crc_err", 16'(crc_err), 16'(m_crc));
        check("addr_err", 16'(addr_err), 16'(m_adr));
        check("tout_err", 16'(tout_err), 16'(m_tout));
        upd_seen  += int'(upd_strb);
        crc_seen  += int'(crc_err);
        adr_seen  += int'(addr_err);
        tout_seen += int'(tout_err);
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            rx_strb = 1'b0;
            rx_data = 8'($urandom);
        end
    endtask

    // Strobe high for 'hold' cycles, then low for at least one cycle.
    task automatic send(input logic [7:0] b, input int hold);
        @(negedge clk);
        rx_data = b;
        rx_strb = 1'b1;
        repeat (hold) @(negedge clk);
        rx_strb = 1'b0;
        rx_data = 8'($urandom);
    endtask

    task automatic send_frame(input logic [7:0] a, input logic [7:0] h, input logic [7:0] l,
                              input logic [7:0] c, input int hold);
        send(8'hA5, hold); send(a, hold); send(h, hold); send(l, hold); send(c, hold);
    endtask

    initial begin
        int u0, c0, a0, t0;
        logic [7:0] a, h, l, c;
        int r, hold;

        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("reset data_3", dut_data[3], 16'h0);
        check("reset upd_index", 16'(upd_index), 16'h0);

        send_frame(8'h03, 8'h12, 8'h34, 8'h49, 1);
        check("A data_3", dut_data[3], 16'h1234);
        check("A upd_strb", 16'(upd_strb), 16'h1);
        check("A upd_index", 16'(upd_index), 16'h3);
        check("A data_4", dut_data[4], 16'h0);
        @(negedge clk);
        check("A upd_strb one cycle", 16'(upd_strb), 16'h0);

        send_frame(8'h09, 8'hFF, 8'hFF, 8'h07, 1);
        check("wrap data_9", dut_data[9], 16'hFFFF);
        check("wrap upd_strb", 16'(upd_strb), 16'h1);
        send_frame(8'h09, 8'hFF, 8'hFF, 8'h08, 1);
        check("bad crc_err", 16'(crc_err), 16'h1);
        check("bad upd_strb", 16'(upd_strb), 16'h0);
        check("bad data_9 held", dut_data[9], 16'hFFFF);

        send_frame(8'h0C, 8'h00, 8'h01, 8'h0D, 1);
        check("addr addr_err", 16'(addr_err), 16'h1);
        check("addr crc_err", 16'(crc_err), 16'h0);
        check("addr upd_strb", 16'(upd_strb), 16'h0);
        check("addr upd_index held", 16'(upd_index), 16'h9);

        t0 = tout_seen;
        send(8'h00, 1); send(8'h55, 1); send(8'hA5, 1); send(8'h03, 1);
        idle(1000);
        check("tout pulses", 16'(tout_seen - t0), 16'h1);
        send_frame(8'h00, 8'hAB, 8'hCD, 8'h78, 1);
        check("after tout data_0", dut_data[0], 16'hABCD);

        // Byte arrives exactly on the expiry cycle: it wins.
        t0 = tout_seen;
        send(8'hA5, 1); send(8'h05, 1); idle(998);
        send(8'h11, 1); send(8'h22, 1); send(8'h38, 1);
        check("edge no tout", 16'(tout_seen - t0), 16'h0);
        check("edge data_5", dut_data[5], 16'h1122);
        // One cycle later it does not.
        send(8'hA5, 1); send(8'h05, 1); idle(999);
        send(8'h33, 1); send(8'h44, 1); send(8'h7C, 1);
        check("late tout", 16'(tout_seen - t0), 16'h1);
        check("late data_5 held", dut_data[5], 16'h1122);

        u0 = upd_seen;
        send_frame(8'h01, 8'h00, 8'h10, 8'h11, 1);
        send_frame(8'h02, 8'h00, 8'h20, 8'h22, 1);
        @(negedge clk);
        check("b2b pulses", 16'(upd_seen - u0), 16'h2);
        check("b2b data_1", dut_data[1], 16'h0010);
        check("b2b data_2", dut_data[2], 16'h0020);

        u0 = upd_seen;
        send_frame(8'h06, 8'h0B, 8'hCD, 8'hDE, 5);
        check("hold5 data_6", dut_data[6], 16'h0BCD);
        check("hold5 one pulse", 16'(upd_seen - u0), 16'h1);

        // Reset after DH with the strobe held high across reset release.
        send(8'hA5, 5); send(8'h01, 5); send(8'h77, 5);
        @(negedge clk);
        rx_data = 8'hA5;
        rx_strb = 1'b1;
        reset   = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("rst data_3", dut_data[3], 16'h0);
        check("rst data_9", dut_data[9], 16'h0);
        check("rst upd_index", 16'(upd_index), 16'h0);
        rx_strb = 1'b0;
        send(8'h07, 5); send(8'h00, 5); send(8'h01, 5); send(8'h08, 5);
        check("held strb ignored", dut_data[7], 16'h0);
        send_frame(8'h07, 8'h00, 8'h01, 8'h08, 5);
        check("post-rst data_7", dut_data[7], 16'h0001);

        c0 = crc_seen; a0 = adr_seen; u0 = upd_seen;
        for (int f = 0; f < 160; f++) begin
            r    = $urandom_range(0, 19);
            hold = $urandom_range(1, 3);
            a    = 8'($urandom_range(0, 11));
            if (r == 19) a = 8'($urandom);
            h    = 8'($urandom);
            l    = 8'($urandom);
            c    = a + h + l;
            if (r == 0) begin
                a = 8'($urandom);
                if (a == 8'hA5) a = 8'h00;
                send(a, hold);
            end else if (r == 1 && f % 40 == 1) begin
                send(8'hA5, hold); send(a, hold);
                idle(TOUT + $urandom_range(0, 3));
            end else begin
                if (r < 5) c = c ^ (8'h01 << $urandom_range(0, 7));
                send(8'hA5, hold);
                idle($urandom_range(0, 2)); send(a, hold);
                idle($urandom_range(0, 2)); send(h, hold);
                idle($urandom_range(0, 2)); send(l, hold);
                idle($urandom_range(0, 2)); send(c, hold);
            end
            idle($urandom_range(0, 1));
        end
        idle(4);
        if (upd_seen == u0 || crc_seen == c0 || adr_seen == a0)
            check("random coverage", 16'h0, 16'h1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
